// File: rtl/pad_btn_conditioner_pkg.sv
// Shared types and constants for the push-button front end of pad_display.
// Optional auto-repeat is enabled by defining PAD_AUTOREPEAT_EN.
package pad_btn_conditioner_pkg;

  localparam int PAD_W = 3;

  typedef enum logic [1:0] {
    DB_RELEASED    = 2'd0,
    DB_PRESS_CHK   = 2'd1,
    DB_PRESSED     = 2'd2,
    DB_RELEASE_CHK = 2'd3
  } db_state_e;

  // Bit 0 is the leftmost pad in [0:2] order.
  localparam logic [0:PAD_W-1] PAD_L = 3'b100;
  localparam logic [0:PAD_W-1] PAD_M = 3'b010;
  localparam logic [0:PAD_W-1] PAD_R = 3'b001;

  // One-hot of the lowest set index; all-zero when nothing is requested.
  function automatic logic [0:PAD_W-1] pick_lowest(input logic [0:PAD_W-1] req);
    logic [0:PAD_W-1] g;
    g = '0;
    for (int i = PAD_W - 1; i >= 0; i--) begin
      if (req[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/pad_btn_conditioner_debounce.sv
// One button: 2-FF synchroniser, debounce FSM and press event.
// With PAD_AUTOREPEAT_EN defined, a held button re-fires every REPEAT_CYCLES cycles.
module pad_btn_conditioner_debounce
  import pad_btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btn_raw,
  output logic      press_evt,
  output logic      held,
  output db_state_e state_dbg
);

  // Stop elaboration on a counter too narrow for the debounce interval.
  if (((longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYCLES)) || (DEBOUNCE_CYCLES < 1) ||
      (REPEAT_CYCLES < 1)) begin : g_bad_cfg
    $error("pad_btn_conditioner_debounce: invalid parameter combination");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             edge_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      state_q <= DB_RELEASED;
      cnt_q   <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_evt = 1'b0;
    case (state_q)
      DB_RELEASED: begin
        if (sync2) begin
          state_d = DB_PRESS_CHK;
          cnt_d   = '0;
        end
      end
      DB_PRESS_CHK: begin
        if (!sync2) begin
          state_d = DB_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DB_PRESSED;
          edge_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DB_PRESSED: begin
        if (!sync2) begin
          state_d = DB_RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      DB_RELEASE_CHK: begin
        if (sync2) begin
          state_d = DB_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = DB_RELEASED;
    endcase
  end

  assign held      = (state_q == DB_PRESSED) || (state_q == DB_RELEASE_CHK);
  assign state_dbg = state_q;

`ifdef PAD_AUTOREPEAT_EN
  localparam int             RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q;
  logic             rpt_run;
  logic             rpt_fire;

  // Counts only while settled in PRESSED; any excursion restarts the period.
  assign rpt_run  = (state_q == DB_PRESSED) && sync2;
  assign rpt_fire = rpt_run && (rpt_q == RPT_LAST);

  always_ff @(posedge clk) begin
    if (rst || !rpt_run || rpt_fire) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_q + RPT_W'(1);
    end
  end

  assign press_evt = edge_evt | rpt_fire;
`else
  assign press_evt = edge_evt;
`endif

endmodule

// File: rtl/pad_btn_conditioner.sv
// Three debounced buttons feeding a pending/arbiter stage that drives one-hot pad pulses.
// Define PAD_AUTOREPEAT_EN to add auto-repeat while a button is held.
module pad_btn_conditioner
  import pad_btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PAD_W-1:0]     btn_raw,
  output logic [0:PAD_W-1]     pad,
  output logic [PAD_W-1:0]     btn_held,
  output logic                 overflow,
  output logic [2*PAD_W-1:0]   dbg_state
);

  // pad is a fire-and-forget pulse: no valid/ready, the consumer counts every high cycle.
  logic [0:PAD_W-1] press_evt;
  logic [0:PAD_W-1] pending_q;
  logic [0:PAD_W-1] pending_d;
  logic [0:PAD_W-1] grant;
  logic             overflow_d;
  db_state_e        db_state [PAD_W];

  for (genvar i = 0; i < PAD_W; i++) begin : g_btn
    pad_btn_conditioner_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .press_evt (press_evt[i]),
      .held      (btn_held[i]),
      .state_dbg (db_state[i])
    );
    assign dbg_state[2*i +: 2] = db_state[i];
  end

  // A bit emitted this cycle is not eligible next cycle, so pad never stays high on one bit.
  always_comb begin
    grant      = pick_lowest(pending_q & ~pad);
    pending_d  = (pending_q & ~grant) | press_evt;
    overflow_d = overflow | (|(press_evt & pending_q & ~grant));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      pad       <= '0;
      overflow  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      pad       <= grant;
      overflow  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pad_btn_conditioner.sv
// Bench for pad_btn_conditioner: run-length debounce reference model, expected-pulse queue,
// directed scenarios followed by randomized button traffic.
`timescale 1ns/1ps
module tb_pad_btn_conditioner;

  localparam int DEB   = 4;
  localparam int RPT   = 16;
  localparam int CNT_W = 4;
  localparam int W     = 35;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_raw = 3'b000;
  logic [0:2] pad;
  logic [2:0] btn_held;
  logic       overflow;
  logic [5:0] dbg_state;

  pad_btn_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .pad       (pad),
    .btn_held  (btn_held),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         cyc = 0;
  logic [2:0] m_s1 = '0;
  logic [2:0] m_s2 = '0;
  logic [2:0] m_held = '0;
  int         m_run [3];
  int         m_rpt [3];
  logic [0:2] m_pend = '0;
  logic [0:2] m_pad = '0;
  logic       m_ovf = 1'b0;

  logic [W-1:0] exp_q [$];   // {cycle, pad}
  int checks = 0;
  int errors = 0;
  int pulse_cnt [3];
  int last_pulse [3];

  // A level is accepted once the synchronised input has disagreed with it for DEB+1 samples.
  always @(posedge clk) begin
    logic [0:2] evt;
    logic [0:2] g;
    logic       s;
    cyc++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_held = '0; m_pend = '0; m_pad = '0; m_ovf = 1'b0;
      for (int i = 0; i < 3; i++) begin m_run[i] = 0; m_rpt[i] = 0; end
    end else begin
      evt = '0;
      for (int i = 0; i < 3; i++) begin
        s = m_s2[i];
`ifdef PAD_AUTOREPEAT_EN
        if (m_held[i] && m_run[i] == 0 && s) begin
          m_rpt[i]++;
          if (m_rpt[i] == RPT) begin m_rpt[i] = 0; evt[i] = 1'b1; end
        end else begin
          m_rpt[i] = 0;
        end
`endif
        if (s != m_held[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_held[i] = s;
            m_run[i]  = 0;
            if (s) evt[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      g = '0;
      for (int i = 2; i >= 0; i--) if (m_pend[i] && !m_pad[i]) begin g = '0; g[i] = 1'b1; end
      for (int i = 0; i < 3; i++) if (evt[i] && m_pend[i] && !g[i]) m_ovf = 1'b1;
      m_pend = (m_pend & ~g) | evt;
      m_pad  = g;
      if (g != 3'b000) exp_q.push_back({cyc[31:0], g});
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  function automatic logic [1:0] exp_state(input logic h, input int run);
    if (h) return (run == 0) ? 2'd2 : 2'd3;
    return (run == 0) ? 2'd0 : 2'd1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    checks++;
    if (btn_held !== m_held) begin
      errors++; $display("FAIL btn_held cyc=%0d got=%b exp=%b", cyc, btn_held, m_held);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++; $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dbg_state[2*i +: 2] !== exp_state(m_held[i], m_run[i])) begin
        errors++;
        $display("FAIL dbg_state[%0d] cyc=%0d got=%0d exp=%0d", i, cyc, dbg_state[2*i +: 2],
                 exp_state(m_held[i], m_run[i]));
      end
    end
    checks++;
    if (!$onehot0(pad)) begin
      errors++; $display("FAIL pad_onehot cyc=%0d got=%b exp=one-hot or zero", cyc, pad);
    end
    if (pad !== 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL pad_unexpected cyc=%0d got=%b exp=000", cyc, pad);
      end else begin
        e = exp_q.pop_front();
        if (e !== {cyc[31:0], pad}) begin
          errors++;
          $display("FAIL pad_pulse got=%b@%0d exp=%b@%0d", pad, cyc, e[2:0], e[W-1:3]);
        end
      end
      for (int i = 0; i < 3; i++) if (pad[i]) begin pulse_cnt[i]++; last_pulse[i] = cyc; end
    end else if (exp_q.size() != 0) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL pad_missing cyc=%0d got=000 exp=%b@%0d", cyc, e[2:0], e[W-1:3]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++; $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete within time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int p;
    for (int i = 0; i < 3; i++) begin pulse_cnt[i] = 0; last_pulse[i] = -1; end
    rst = 1'b1; btn_raw = 3'b000;
    tick(3);
    expect_eq("reset_pad", int'(pad), 0);
    expect_eq("reset_btn_held", int'(btn_held), 0);
    expect_eq("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    tick(2);

    // Clean press of button 1.
    t0 = cyc; p = pulse_cnt[1];
    btn_raw[1] = 1'b1;
    tick(20);
    expect_eq("clean_press_count", pulse_cnt[1] - p, 1);
    expect_eq("clean_press_latency", last_pulse[1], t0 + 8);
    expect_eq("clean_press_held", int'(btn_held[1]), 1);
    btn_raw[1] = 1'b0;
    tick(12);
    expect_eq("clean_release_held", int'(btn_held[1]), 0);

    // Bounce on button 0 before settling high.
    p = pulse_cnt[0];
    btn_raw[0] = 1'b1; tick(1); btn_raw[0] = 1'b0; tick(1);
    btn_raw[0] = 1'b1; tick(1); btn_raw[0] = 1'b0; tick(1);
    t0 = cyc; btn_raw[0] = 1'b1;
    tick(20);
    expect_eq("bounce_count", pulse_cnt[0] - p, 1);
    expect_eq("bounce_latency", last_pulse[0], t0 + 8);
    btn_raw[0] = 1'b0;
    tick(12);

    // Simultaneous press serialises 0,1,2.
    t0 = cyc;
    btn_raw = 3'b111;
    tick(20);
    expect_eq("simul_pad0_cycle", last_pulse[0], t0 + 8);
    expect_eq("simul_pad1_cycle", last_pulse[1], t0 + 9);
    expect_eq("simul_pad2_cycle", last_pulse[2], t0 + 10);
    expect_eq("simul_overflow", int'(overflow), 0);
    btn_raw = 3'b000;
    tick(12);

    // Reset mid PRESS_CHK discards the press.
    p = pulse_cnt[2];
    btn_raw[2] = 1'b1;
    tick(4);
    rst = 1'b1; btn_raw[2] = 1'b0;
    tick(1);
    rst = 1'b0;
    expect_eq("midreset_pad", int'(pad), 0);
    expect_eq("midreset_held", int'(btn_held), 0);
    expect_eq("midreset_overflow", int'(overflow), 0);
    tick(12);
    expect_eq("midreset_no_pulse", pulse_cnt[2] - p, 0);
    btn_raw[2] = 1'b1;
    tick(20);
    expect_eq("after_reset_press", pulse_cnt[2] - p, 1);
    btn_raw[2] = 1'b0;
    tick(12);

    // Long hold: one pulse, or auto-repeat pulses at 8, 24, 40.
    p = pulse_cnt[2];
    btn_raw[2] = 1'b1;
    tick(50);
`ifdef PAD_AUTOREPEAT_EN
    expect_eq("long_hold_pulses", pulse_cnt[2] - p, 3);
`else
    expect_eq("long_hold_pulses", pulse_cnt[2] - p, 1);
`endif
    btn_raw[2] = 1'b0;
    tick(12);

    // One-cycle release glitch while held.
    btn_raw[0] = 1'b1;
    tick(15);
    p = pulse_cnt[0];
    btn_raw[0] = 1'b0; tick(1); btn_raw[0] = 1'b1;
    tick(15);
    expect_eq("glitch_no_pulse", pulse_cnt[0] - p, 0);
    expect_eq("glitch_held", int'(btn_held[0]), 1);
    btn_raw[0] = 1'b0;
    tick(12);

    // Acceptance boundary: DEB cycles high is rejected, DEB+1 accepted.
    p = pulse_cnt[1];
    btn_raw[1] = 1'b1; tick(DEB); btn_raw[1] = 1'b0;
    tick(12);
    expect_eq("short_pulse_rejected", pulse_cnt[1] - p, 0);
    btn_raw[1] = 1'b1; tick(DEB + 1); btn_raw[1] = 1'b0;
    tick(12);
    expect_eq("min_pulse_accepted", pulse_cnt[1] - p, 1);
    tick(12);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 300; k++) begin
      btn_raw = 3'($urandom_range(0, 7));
      rst     = ($urandom_range(0, 40) == 0);
      tick($urandom_range(1, 10));
    end
    rst = 1'b0;
    btn_raw = 3'b000;
    tick(30);
    expect_eq("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
